vx_ti_mem_responder: RTL and testbench
======================================

VX_TI_MEM_RESPONDER -- requirements
Module: VX_ti_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, response/write word width in bits (one DATA_SIZE beat).
REQ-002 SHALL have parameter ADDR_WIDTH, 32, request byte-address width.
REQ-003 SHALL have parameter TAG_WIDTH, 2, request tag width, echoed on the response.
REQ-004 SHALL have parameter BASE_ADDR, 32'h0, byte address of word 0.
REQ-005 SHALL have parameter NUM_WORDS, 1024, backing storage depth in DATA_WIDTH words.
REQ-006 SHALL have parameter LATENCY, 2, minimum accept-to-response cycles (>=1).
REQ-007 SHALL have parameter RSP_DEPTH, 4, response queue depth (power of two, >=2).
REQ-008 SHALL have port clk  in  1  clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-010 SHALL have port req_valid  in  1  request present.
REQ-011 SHALL have port req_rw  in  1  0 = read, 1 = write.
REQ-012 SHALL have port req_addr  in  ADDR_WIDTH  byte address.
REQ-013 SHALL have port req_byteen  in  DATA_WIDTH/8  write byte enables.
REQ-014 SHALL have port req_data  in  DATA_WIDTH  write data.
REQ-015 SHALL have port req_tag  in  TAG_WIDTH  request tag.
REQ-016 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-017 SHALL have port rsp_valid  out  1  response present.
REQ-018 SHALL have port rsp_data  out  DATA_WIDTH  read data.
REQ-019 SHALL have port rsp_tag  out  TAG_WIDTH  echoed tag.
REQ-020 SHALL have port rsp_err  out  1  out-of-range address flag.
REQ-021 SHALL have port rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.

Function
REQ-022 SHALL compute word index = (req_addr - BASE_ADDR) >> log2(DATA_WIDTH/8), ignoring low offset bits.
REQ-023 SHALL treat an address below BASE_ADDR or with index >= NUM_WORDS as out of range.
REQ-024 SHALL, on an accepted in-range write, update only the enabled bytes in the same cycle and produce no response.
REQ-025 SHALL drop an out-of-range write silently, with no response and no storage change.
REQ-026 SHALL return one response per accepted read, in acceptance order, with the request's tag.
REQ-027 SHALL return rsp_data = 0 and rsp_err = 1 for an out-of-range read, else rsp_err = 0.
REQ-028 SHALL present a read accepted at cycle N on rsp_valid no earlier than N+LATENCY, and exactly at N+LATENCY when the queue is empty.
REQ-029 SHALL return the newly written bytes for a read accepted in any cycle after an accepted write to the same word.
REQ-030 SHALL track credits = reads in pipeline + queue occupancy; req_ready = (credits < RSP_DEPTH), writes included in that gating.
REQ-031 SHALL keep credits unchanged when a read is accepted and a response is consumed in the same cycle.
REQ-032 SHALL hold rsp_valid, rsp_data, rsp_tag and rsp_err stable while rsp_valid && !rsp_ready.
REQ-033 SHALL make req_ready independent of the same-cycle req_valid (no combinational loop).

Reset
REQ-034 SHALL, during reset, drive req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_err = 0, and set credits to 0.
REQ-035 SHALL discard in-flight reads and queued responses on reset mid-operation; storage contents are not reset.
REQ-036 SHALL assert req_ready in the first cycle after reset deasserts.

Structure
REQ-037 SHALL place ti_mem_req_t / ti_mem_rsp_t typedefs and BVH_NODE_BYTES, TRI_NODE_BYTES, TRI_INDEX_BYTES in VX_ti_pkg.
REQ-038 SHALL implement the response queue as the single sub-module VX_fifo_queue; the LATENCY shift pipeline and storage stay in-module.

Verification
REQ-039 SHALL cover: write 0x1122334455667788 to BASE_ADDR+8 with byteen=8'hFF, then read with tag 2 -> rsp_data=0x1122334455667788, rsp_tag=2, rsp_err=0, exactly LATENCY cycles after accept.
REQ-040 SHALL cover: write byteen=8'h0F data=0xAAAAAAAABBBBBBBB over an all-ones word, then read -> 0xFFFFFFFFBBBBBBBB.
REQ-041 SHALL cover: rsp_ready=0, issue 5 back-to-back reads -> 4 accepted, req_ready low on the 5th; release rsp_ready -> tags returned in order 0,1,2,3.
REQ-042 SHALL cover: read at BASE_ADDR + NUM_WORDS*8 -> rsp_err=1, rsp_data=0.
REQ-043 SHALL cover: rsp_ready=1 with a continuous read stream -> one accept and one response every cycle, credits constant.
REQ-044 SHALL cover: reset asserted with 3 reads outstanding -> no responses afterwards, req_ready=1 the first cycle after reset, previously written data still readable.

Source files
------------

// File: rtl/VX_ti_pkg.sv
// VX_ti_pkg: shared request/response types and node-size constants for the TI memory path.
// Rev 1.0
`default_nettype none

package VX_ti_pkg;

   localparam int TI_DATA_WIDTH   = 64;
   localparam int TI_ADDR_WIDTH   = 32;
   localparam int TI_TAG_WIDTH    = 2;

   localparam int BVH_NODE_BYTES  = 64;
   localparam int TRI_NODE_BYTES  = 48;
   localparam int TRI_INDEX_BYTES = 4;

   typedef struct packed {
      logic                         rw;
      logic [TI_ADDR_WIDTH-1:0]     addr;
      logic [TI_DATA_WIDTH/8-1:0]   byteen;
      logic [TI_DATA_WIDTH-1:0]     data;
      logic [TI_TAG_WIDTH-1:0]      tag;
   } ti_mem_req_t;

   typedef struct packed {
      logic [TI_DATA_WIDTH-1:0]     data;
      logic [TI_TAG_WIDTH-1:0]      tag;
      logic                         err;
   } ti_mem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/VX_fifo_queue.sv
// VX_fifo_queue: register-array FIFO with registered head; a push becomes visible next cycle.
// Rev 1.0
`default_nettype none

module VX_fifo_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         if (i_pop)  r_rd <= r_rd + AW'(1);
         if (i_push && !i_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!i_push && i_pop) r_count <= r_count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end

   assign o_data  = r_mem[r_rd];
   assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vx_ti_mem_responder.sv
// vx_ti_mem_responder: byte-enabled word store; reads answered in order after LATENCY cycles.
// Rev 1.0
`default_nettype none

module vx_ti_mem_responder
   import VX_ti_pkg::*;
#(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    TAG_WIDTH  = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_WORDS  = 1024,
   parameter int                    LATENCY    = 2,
   parameter int                    RSP_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic                    req_rw,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_byteen,
   input  logic [DATA_WIDTH-1:0]   req_data,
   input  logic [TAG_WIDTH-1:0]    req_tag,
   output logic                    req_ready,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [TAG_WIDTH-1:0]    rsp_tag,
   output logic                    rsp_err,
   input  logic                    rsp_ready
);

   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int OFF_BITS = $clog2(BYTES);
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int PW       = TAG_WIDTH + 1 + DATA_WIDTH;
   localparam int CW       = $clog2(RSP_DEPTH + 1);

   logic [ADDR_WIDTH-1:0] w_offset;
   logic [ADDR_WIDTH-1:0] w_index;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_q_empty;
   logic [PW-1:0]         w_rd_payload;
   logic [PW-1:0]         w_push_payload;
   logic [PW-1:0]         w_q_payload;

   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
   logic [CW-1:0]         r_credits;

   assign w_offset   = req_addr - BASE_ADDR;
   assign w_index    = w_offset >> OFF_BITS;
   assign w_idx      = w_index[IDX_W-1:0];
   assign w_in_range = (req_addr >= BASE_ADDR) && (w_index < ADDR_WIDTH'(NUM_WORDS));

   // Credits count every read not yet consumed, so the queue can never overflow.
   assign req_ready = !reset && (r_credits < CW'(RSP_DEPTH));
   assign w_accept  = req_valid && req_ready;
   assign w_wr_acc  = w_accept && req_rw && w_in_range;
   assign w_rd_acc  = w_accept && !req_rw;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         for (int b = 0; b < BYTES; b++) begin
            if (req_byteen[b]) r_mem[w_idx][b*8 +: 8] <= req_data[b*8 +: 8];
         end
      end
   end

   assign w_rd_payload = {req_tag, !w_in_range, (w_in_range ? r_mem[w_idx] : {DATA_WIDTH{1'b0}})};

   // The queue's registered head adds the final cycle, so the shift chain is LATENCY-1 deep.
   if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] r_vld;
      logic [PW-1:0]      r_dat [LATENCY-1];

      always_ff @(posedge clk) begin
         if (reset) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= w_rd_acc;
            for (int i = 1; i < LATENCY-1; i++) r_vld[i] <= r_vld[i-1];
         end
      end

      always_ff @(posedge clk) begin
         r_dat[0] <= w_rd_payload;
         for (int i = 1; i < LATENCY-1; i++) r_dat[i] <= r_dat[i-1];
      end

      assign w_push         = r_vld[LATENCY-2];
      assign w_push_payload = r_dat[LATENCY-2];
   end else begin : g_direct
      assign w_push         = w_rd_acc;
      assign w_push_payload = w_rd_payload;
   end

   VX_fifo_queue #(
      .WIDTH (PW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_queue (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_payload),
      .i_pop   (w_pop),
      .o_data  (w_q_payload),
      .o_empty (w_q_empty)
   );

   assign rsp_valid = !reset && !w_q_empty;
   assign w_pop     = rsp_valid && rsp_ready;
   assign {rsp_tag, rsp_err, rsp_data} = rsp_valid ? w_q_payload : {PW{1'b0}};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_credits <= '0;
      end else if (w_rd_acc && !w_pop) begin
         r_credits <= r_credits + CW'(1);
      end else if (!w_rd_acc && w_pop) begin
         r_credits <= r_credits - CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vx_ti_mem_responder.sv
// tb_vx_ti_mem_responder: randomized and directed stimulus against a queue/array reference model.
// Rev 1.0
`default_nettype none

module tb_vx_ti_mem_responder;

   localparam int          DW    = 64;
   localparam int          AW    = 32;
   localparam int          TW    = 2;
   localparam logic [31:0] BASE  = 32'h1000;
   localparam int          NW    = 64;
   localparam int          LAT   = 2;
   localparam int          DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_rw = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_byteen = '0;
   logic [DW-1:0] req_data = '0;
   logic [TW-1:0] req_tag = '0;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [TW-1:0] rsp_tag;
   logic          rsp_err;
   logic          rsp_ready = 1'b1;

   vx_ti_mem_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .TAG_WIDTH  (TW),
      .BASE_ADDR  (BASE),
      .NUM_WORDS  (NW),
      .LATENCY    (LAT),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_byteen (req_byteen),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      logic          err;
      int            acc;
      bit            exact;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mdl [int];
   logic [TW-1:0] pop_log[$];
   int            checks = 0;
   int            errors = 0;
   int            n_acc = 0;
   int            n_pop = 0;
   logic [DW-1:0] last_data;
   logic [TW-1:0] last_tag;
   logic          last_err;
   bit            head_seen = 0;
   bit            held = 0;
   logic [DW-1:0] h_data;
   logic [TW:0]   h_meta;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_rng(logic [31:0] a);
      longint d;
      d = longint'(a) - longint'(BASE);
      return (d >= 0) && ((d / 8) < NW);
   endfunction

   function automatic int widx(logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 8);
   endfunction

   // Scoreboard and reference model, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         chk("reset_req_ready", req_ready, 0);
         chk("reset_rsp_valid", rsp_valid, 0);
         chk("reset_rsp_fields", {rsp_tag, rsp_err, rsp_data[60:0]}, 0);
         q.delete();
         head_seen = 0;
         held = 0;
      end else begin
         chk("req_ready_credits", req_ready, (q.size() < DEPTH));
         if (held) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, h_data);
            chk("hold_tag_err", {rsp_tag, rsp_err}, h_meta);
         end
         if (rsp_valid) begin
            if (q.size() == 0) begin
               chk("spurious_rsp", 1, 0);
            end else begin
               if (!head_seen) begin
                  if (q[0].exact) chk("latency_exact", cyc - q[0].acc, LAT);
                  else            chk("latency_min", ((cyc - q[0].acc) >= LAT), 1);
                  head_seen = 1;
               end
               if (rsp_ready) begin
                  chk("rsp_data", rsp_data, q[0].data);
                  chk("rsp_tag", rsp_tag, q[0].tag);
                  chk("rsp_err", rsp_err, q[0].err);
                  last_data = rsp_data;
                  last_tag  = rsp_tag;
                  last_err  = rsp_err;
                  pop_log.push_back(rsp_tag);
                  void'(q.pop_front());
                  head_seen = 0;
                  n_pop++;
               end
            end
         end
         held   = rsp_valid && !rsp_ready;
         h_data = rsp_data;
         h_meta = {rsp_tag, rsp_err};
         if (req_valid && req_ready) begin
            n_acc++;
            if (req_rw) begin
               if (in_rng(req_addr)) begin
                  logic [DW-1:0] w;
                  w = mdl.exists(widx(req_addr)) ? mdl[widx(req_addr)] : {DW{1'bx}};
                  for (int b = 0; b < 8; b++)
                     if (req_byteen[b]) w[b*8 +: 8] = req_data[b*8 +: 8];
                  mdl[widx(req_addr)] = w;
               end
            end else begin
               exp_t e;
               e.err   = !in_rng(req_addr);
               e.data  = '0;
               if (!e.err) e.data = mdl.exists(widx(req_addr)) ? mdl[widx(req_addr)] : {DW{1'bx}};
               e.tag   = req_tag;
               e.acc   = cyc;
               e.exact = (q.size() == 0);
               q.push_back(e);
            end
         end
      end
   end

   task automatic issue(bit rw, logic [31:0] a, logic [7:0] be, logic [63:0] d, logic [1:0] t);
      bit ok;
      ok = 0;
      req_valid = 1; req_rw = rw; req_addr = a; req_byteen = be; req_data = d; req_tag = t;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = (q.size() == 0);
      end
      if (!ok) chk("drain_timeout", q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0;
      bit ok;
      reset = 1; rsp_ready = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      for (int i = 0; i < NW; i++) issue(1, BASE + 32'(i*8), 8'hFF, {$urandom, $urandom}, 0);

      // full-word write then tagged read
      issue(1, BASE + 8, 8'hFF, 64'h1122334455667788, 0);
      issue(0, BASE + 8, 8'h00, 64'h0, 2);
      drain();
      chk("rd_full_data", last_data, 64'h1122334455667788);
      chk("rd_full_tag", last_tag, 2);
      chk("rd_full_err", last_err, 0);

      // partial byte-enable write over all ones
      issue(1, BASE + 16, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 0);
      issue(1, BASE + 16, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0);
      issue(0, BASE + 16, 8'h00, 64'h0, 1);
      drain();
      chk("rd_partial_data", last_data, 64'hFFFFFFFFBBBBBBBB);

      // out-of-range reads, above and below the window
      issue(0, BASE + 32'(NW*8), 8'h00, 64'h0, 3);
      drain();
      chk("oor_hi_err", last_err, 1);
      chk("oor_hi_data", last_data, 0);
      issue(0, BASE - 8, 8'h00, 64'h0, 1);
      drain();
      chk("oor_lo_err", last_err, 1);

      // backpressure: four reads fill the credits, fifth stalls
      rsp_ready = 0;
      pop_log.delete();
      for (int t = 0; t < 4; t++) issue(0, BASE + 32'(t*8), 8'h00, 64'h0, 2'(t));
      req_valid = 1; req_rw = 0; req_addr = BASE; req_tag = 0;
      repeat (3) begin
         @(negedge clk);
         chk("full_req_ready", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = 1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) chk("fifth_accept_timeout", 0, 1);
      @(posedge clk); #1 req_valid = 0;
      drain();
      chk("order_count", pop_log.size(), 5);
      if (pop_log.size() >= 4)
         for (int i = 0; i < 4; i++) chk("order_tag", pop_log[i], 64'(i));

      // continuous read stream with rsp_ready held high
      n_acc = 0; n_pop = 0;
      req_valid = 1; req_rw = 0; req_addr = BASE + 24; req_tag = 1;
      repeat (20) @(posedge clk);
      #1 req_valid = 0;
      chk("stream_accepts", n_acc, 20);
      chk("stream_pops", n_pop, 18);
      drain();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         req_valid  = ($urandom % 4) != 0;
         req_rw     = ($urandom % 3) == 0;
         req_addr   = BASE - 32 + $urandom_range(0, NW*8 + 64);
         req_byteen = 8'($urandom);
         req_data   = {$urandom, $urandom};
         req_tag    = 2'($urandom);
         rsp_ready  = ($urandom % 10) < 7;
         @(posedge clk); #1;
      end
      req_valid = 0; rsp_ready = 1;
      drain();

      // reset with reads outstanding; storage must survive
      rsp_ready = 0;
      for (int t = 1; t < 4; t++) issue(0, BASE + 32'(t*8), 8'h00, 64'h0, 2'(t));
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0; rsp_ready = 1;
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1);
      @(posedge clk); #1;
      p0 = n_pop;
      repeat (10) @(posedge clk);
      #1;
      chk("no_rsp_after_reset", n_pop - p0, 0);
      issue(0, BASE + 16, 8'h00, 64'h0, 2);
      drain();
      chk("persist_err", last_err, 0);
      chk("persist_known", ^last_data !== 1'bx, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
